// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: size codes, FSM states,
// byte-enable generation and misalignment detection.
package lsu_pkg;

    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ACCESS,
        LSU_RESP
    } lsu_state_e;

    // The reserved size code 2'b11 behaves as a word everywhere.
    function automatic logic [3:0] lsu_byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            LSU_BYTE: return 4'b0001 << addr_lo;
            LSU_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            LSU_BYTE: return 1'b0;
            LSU_HALF: return addr_lo[0];
            default:  return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, store-data replication and
// load-data lane extraction with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // NOTE: every output of a combinational block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        be        = lsu_byte_en(size, addr_lo);
        rd_byte   = rdata[{addr_lo, 3'b000} +: 8];
        rd_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            LSU_BYTE: begin
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{rd_byte[7] & ~is_unsigned}}, rd_byte};
            end
            LSU_HALF: begin
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{rd_half[15] & ~is_unsigned}}, rd_half};
            end
            default: begin
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load/store per transaction, stalls via busy.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned requests on misalign_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_err
`endif
);

    lsu_state_e  state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  addr_lo_q;

    logic [1:0]  al_size;
    logic        al_uns;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    // The single aligner serves the incoming request while idle (to register
    // the memory port) and the latched request afterwards (to extract loads).
    always_comb begin
        if (state == LSU_IDLE) begin
            al_size    = req_size;
            al_uns     = req_unsigned;
            al_addr_lo = req_addr[1:0];
        end else begin
            al_size    = size_q;
            al_uns     = uns_q;
            al_addr_lo = addr_lo_q;
        end
    end

    lsu_lane_align u_align (
        .size        (al_size),
        .is_unsigned (al_uns),
        .addr_lo     (al_addr_lo),
        .wdata       (req_wdata),
        .rdata       (mem_rdata),
        .be          (al_be),
        .wdata_rep   (al_wdata),
        .rdata_ext   (al_rdata)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LSU_IDLE;
            we_q         <= 1'b0;
            size_q       <= LSU_BYTE;
            uns_q        <= 1'b0;
            addr_lo_q    <= 2'b00;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        addr_lo_q <= req_addr[1:0];
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (lsu_misaligned(req_size, req_addr[1:0])) begin
                            state        <= LSU_RESP;
                            resp_valid   <= 1'b1;
                            resp_rdata   <= '0;
                            misalign_err <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            state     <= LSU_ACCESS;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                        end
                    end
                end
                LSU_ACCESS: begin
                    if (mem_ack) begin
                        state      <= LSU_RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= '0;
                        mem_be     <= '0;
                        mem_wdata  <= '0;
                        resp_valid <= 1'b1;
                        resp_rdata <= we_q ? 32'h0 : al_rdata;
                    end
                end
                LSU_RESP: begin
                    state      <= LSU_IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign_err <= 1'b0;
`endif
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases from the test plan
// followed by randomized traffic against a transaction-level reference model.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, busy;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .busy         (busy),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

`ifndef LSU_MISALIGN_TRAP_EN
    assign misalign_err = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'd0) return 4'(1 << a);
        if (sz == 2'd1) return a[1] ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return 32'(w[7:0]) * 32'h0101_0101;
        if (sz == 2'd1) return 32'(w[15:0]) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns,
                                             input logic [1:0] a, input logic [31:0] w);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * a)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic bit misal(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return a[0];
        return a != 2'b00;
    endfunction

    // Model phases: 0 waiting, 1 memory access outstanding, 2 completing.
    int          m_phase = 0;
    bit          m_we, m_uns, m_trap = 1'b0;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata = 32'h0;
    bit          started = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_phase = 0;
            m_rdata = 32'h0;
            m_trap  = 1'b0;
        end else begin
            case (m_phase)
                0: if (req_valid) begin
                    m_we = req_we; m_size = req_size; m_uns = req_unsigned;
                    m_addr = req_addr; m_wdata = req_wdata;
                    if (TRAP && misal(req_size, req_addr[1:0])) begin
                        m_phase = 2; m_trap = 1'b1; m_rdata = 32'h0;
                    end else begin
                        m_phase = 1;
                    end
                end
                1: if (mem_ack) begin
                    m_rdata = m_we ? 32'h0 : exp_load(m_size, m_uns, m_addr[1:0], mem_rdata);
                    m_phase = 2;
                end
                default: begin
                    m_phase = 0;
                    m_trap  = 1'b0;
                end
            endcase
        end
        started = 1'b1;
    end

    // Compare process: every output on every cycle, memory fields while an access is due.
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("req_ready", req_ready, 32'(m_phase == 0));
            check("busy", busy, 32'(m_phase != 0));
            check("mem_req", mem_req, 32'(m_phase == 1));
            check("resp_valid", resp_valid, 32'(m_phase == 2));
            check("resp_rdata", resp_rdata, m_rdata);
`ifdef LSU_MISALIGN_TRAP_EN
            check("misalign_err", misalign_err, 32'(m_trap && m_phase == 2));
`endif
            if (m_phase == 1) begin
                check("mem_we", mem_we, 32'(m_we));
                check("mem_addr", mem_addr, m_addr & 32'hFFFF_FFFC);
                check("mem_be", mem_be, exp_be(m_size, m_addr[1:0]));
                check("mem_wdata", mem_wdata, exp_wd(m_size, m_wdata));
            end
        end
    end

    // ---------------- memory responder ----------------
    bit          manual = 1'b0;
    bit          rand_mem = 1'b0;
    int          fixed_delay = 1;
    logic [31:0] dir_rdata = 32'h0;

    initial begin
        int cnt = 0;
        int cur_delay = 1;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!manual) begin
                if (mem_req) begin
                    if (cnt == 0) cur_delay = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
                    cnt++;
                    mem_ack   = (cnt == cur_delay);
                    mem_rdata = rand_mem ? $urandom : dir_rdata;
                end else begin
                    cnt       = 0;
                    mem_ack   = rand_mem && ($urandom_range(0, 5) == 0);
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        bit got = 1'b0;
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            got = req_ready;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!got) check("accept_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        @(negedge clk);
        check("idle_reached", req_ready, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 32'd1);
        check("rst_busy", busy, 32'd0);
        check("rst_mem_req", mem_req, 32'd0);
        check("rst_resp_valid", resp_valid, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_be", mem_be, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_misalign", misalign_err, 32'd0);

        // Load byte signed / unsigned
        fixed_delay = 1; dir_rdata = 32'h1234_F678;
        issue(1'b0, 2'd0, 1'b0, 32'h301, 32'h0);
        @(negedge clk); @(negedge clk);
        check("lb_valid", resp_valid, 32'd1);
        check("lb_rdata", resp_rdata, 32'hFFFF_FFF6);
        wait_idle();
        issue(1'b0, 2'd0, 1'b1, 32'h301, 32'h0);
        @(negedge clk); @(negedge clk);
        check("lbu_rdata", resp_rdata, 32'h0000_00F6);
        wait_idle();

        // Store word, ack in the first access cycle
        issue(1'b1, 2'd2, 1'b0, 32'h104, 32'hDEAD_BEEF);
        @(negedge clk);
        check("sw_mem_we", mem_we, 32'd1);
        check("sw_mem_addr", mem_addr, 32'h104);
        check("sw_mem_be", mem_be, 32'hF);
        check("sw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("sw_valid_t2", resp_valid, 32'd1);
        check("sw_rdata", resp_rdata, 32'h0);
        wait_idle();

        // Store byte
        issue(1'b1, 2'd0, 1'b0, 32'h203, 32'h0000_00A5);
        @(negedge clk);
        check("sb_mem_addr", mem_addr, 32'h200);
        check("sb_mem_be", mem_be, 32'h8);
        check("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        wait_idle();

        // Load half, ack delayed to the fifth access cycle
        fixed_delay = 5; dir_rdata = 32'h8001_0000;
        issue(1'b0, 2'd1, 1'b0, 32'h402, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lh_busy", busy, 32'd1);
            check("lh_ready", req_ready, 32'd0);
            check("lh_mem_req", mem_req, 32'd1);
            check("lh_mem_addr", mem_addr, 32'h400);
            check("lh_mem_be", mem_be, 32'hC);
        end
        @(negedge clk);
        check("lh_valid", resp_valid, 32'd1);
        check("lh_rdata", resp_rdata, 32'hFFFF_8001);
        wait_idle();

        // Reset while the access is outstanding, then a late ack
        manual = 1'b1; mem_ack = 1'b0;
        issue(1'b0, 2'd2, 1'b0, 32'h500, 32'h0);
        @(negedge clk);
        check("rs_mem_req", mem_req, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        check("rs_mem_req_drop", mem_req, 32'd0);
        check("rs_busy", busy, 32'd0);
        check("rs_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rs_no_resp", resp_valid, 32'd0);
            @(negedge clk);
        end
        manual = 1'b0; fixed_delay = 2; dir_rdata = 32'h1357_9BDF;
        issue(1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("rs_next_valid", resp_valid, 32'd1);
        check("rs_next_rdata", resp_rdata, 32'h1357_9BDF);
        wait_idle();

        // Misaligned word load
        fixed_delay = 1; dir_rdata = 32'h0BAD_0BAD;
        issue(1'b0, 2'd2, 1'b0, 32'h106, 32'h0);
        @(negedge clk);
        if (TRAP) begin
            check("mis_valid", resp_valid, 32'd1);
            check("mis_err", misalign_err, 32'd1);
            check("mis_no_mem_req", mem_req, 32'd0);
            check("mis_rdata", resp_rdata, 32'd0);
        end else begin
            check("mis_mem_req", mem_req, 32'd1);
            check("mis_mem_addr", mem_addr, 32'h104);
            check("mis_mem_be", mem_be, 32'hF);
        end
        wait_idle();

        // Randomized traffic; requests are often held while the unit is busy
        rand_mem = 1'b1; fixed_delay = 0;
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            a = $urandom;
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        rand_mem = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
